// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor: dif = a - b - bin, retiring DIGIT bits per clock.
// Operands enter on an in_valid/in_ready handshake; results leave on out_valid/out_ready.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dif,
  output logic             bor,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject illegal WIDTH/DIGIT combinations at elaboration
  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_subtractor: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   dif_q, dif_d;
  logic               bor_q, bor_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               ai, bi, di;

  // Next-state: handshake control plus the DIGIT-wide chain of full-subtractor cells
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    br_d        = br_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    out_valid_d = out_valid_q;
    dif_d       = dif_q;
    bor_d       = bor_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    ai          = 1'b0;
    bi          = 1'b0;
    di          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Bits are retired low to high; each result bit enters the result register at the MSB
        for (int unsigned i = 0; i < DIGIT; i++) begin
          ai     = a_sh_d[0];
          bi     = b_sh_d[0];
          di     = ai ^ bi ^ br_d;
          br_d   = (~ai & bi) | (~(ai ^ bi) & br_d);
          res_d  = (res_d >> 1) | (WIDTH'(di) << (WIDTH - 1));
          a_sh_d = a_sh_d >> 1;
          b_sh_d = b_sh_d >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          dif_d       = res_d;
          bor_d       = br_d;
          ovf_d       = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
          zero_d      = (res_d == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready only while the next state is IDLE, so DONE never accepts on its exit edge
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dif_q       <= '0;
      bor_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      br_q        <= br_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dif_q       <= dif_d;
      bor_q       <= bor_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dif       = dif_q;
  assign bor       = bor_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (DIGIT = 1, 4, 8) at WIDTH = 8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_s, b_s;
  logic       bin_s;
  logic       in_valid  [3];
  logic       out_ready [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic [7:0] dif       [3];
  logic       bor       [3];
  logic       ovf       [3];
  logic       zero      [3];

  int checks   = 0;
  int failures = 0;
  int lat_e [3] = '{8, 2, 1};

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s), .b(b_s), .bin(bin_s), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .dif(dif[0]), .bor(bor[0]), .ovf(ovf[0]), .zero(zero[0]));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s), .b(b_s), .bin(bin_s), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .dif(dif[1]), .bor(bor[1]), .ovf(ovf[1]), .zero(zero[1]));

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s), .b(b_s), .bin(bin_s), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .dif(dif[2]), .bor(bor[2]), .ovf(ovf[2]), .zero(zero[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 9-bit arithmetic difference; bit 8 is the borrow-out
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin,
                       output logic [7:0] e_dif, output logic e_bor, output logic e_ovf,
                       output logic e_zero);
    logic [8:0] full;
    full   = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
    e_dif  = full[7:0];
    e_bor  = full[8];
    e_ovf  = (ma[7] != mb[7]) && (e_dif[7] != ma[7]);
    e_zero = (e_dif == 8'd0);
  endtask

  // One complete transaction on instance k with out_ready held high
  task automatic run_op(input int k, input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                        input logic [7:0] e_dif, input logic e_bor, input logic e_ovf,
                        input logic e_zero, input string tag);
    int lat;
    @(negedge clk);
    chk($sformatf("%s.in_ready", tag), 32'(in_ready[k]), 32'd1);
    a_s = va; b_s = vb; bin_s = vbin;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s.latency", tag), 32'(lat), 32'(lat_e[k]));
    chk($sformatf("%s.dif", tag), 32'(dif[k]), 32'(e_dif));
    chk($sformatf("%s.bor", tag), 32'(bor[k]), 32'(e_bor));
    chk($sformatf("%s.ovf", tag), 32'(ovf[k]), 32'(e_ovf));
    chk($sformatf("%s.zero", tag), 32'(zero[k]), 32'(e_zero));
    @(posedge clk); #1;
    chk($sformatf("%s.out_valid_clr", tag), 32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb, m_dif;
    logic       rbin, m_bor, m_ovf, m_zero;
    int         lat, vcnt;
    logic [7:0] h_dif;

    rst_n = 1'b0;
    a_s = 8'd0; b_s = 8'd0; bin_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.in_ready", k), 32'(in_ready[k]), 32'd0);
      chk($sformatf("rst%0d.out_valid", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst%0d.dif", k), 32'(dif[k]), 32'd0);
      chk($sformatf("rst%0d.flags", k), 32'({bor[k], ovf[k], zero[k]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready_low", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("rel.in_ready_high", 32'(in_ready[0]), 32'd1);

    // Directed vectors, hand-computed
    run_op(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "d1_5m3");
    run_op(0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "d1_3m5");
    run_op(0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "d1_0m0b");
    run_op(0, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "d1_eq");
    run_op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "d1_ovfn");
    run_op(0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, "d1_ovfp");
    run_op(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "d4_5m3");
    run_op(1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, "d4_ovfp");
    run_op(2, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "d8_0m0b");
    run_op(2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "d8_ovfn");

    // Backpressure with an ignored in_valid pulse during BUSY: 0x33 - 0x11 - 1 = 0x21
    out_ready[0] = 1'b0;
    @(negedge clk);
    a_s = 8'h33; b_s = 8'h11; bin_s = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    @(negedge clk);
    a_s = 8'hFF; b_s = 8'h00; bin_s = 1'b0;
    in_valid[0] = 1'b1;
    chk("bp.busy_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    lat++;
    @(posedge clk); #1;
    lat++;
    in_valid[0] = 1'b0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd8);
    chk("bp.dif", 32'(dif[0]), 32'h21);
    chk("bp.flags", 32'({bor[0], ovf[0], zero[0]}), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.out_valid", c), 32'(out_valid[0]), 32'd1);
      chk($sformatf("bp.hold%0d.in_ready", c), 32'(in_ready[0]), 32'd0);
      chk($sformatf("bp.hold%0d.dif", c), 32'(dif[0]), 32'h21);
      chk($sformatf("bp.hold%0d.flags", c), 32'({bor[0], ovf[0], zero[0]}), 32'd0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp.out_valid_clr", 32'(out_valid[0]), 32'd0);
    chk("bp.in_ready_back", 32'(in_ready[0]), 32'd1);

    // Random sweep against the arithmetic reference on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra   = 8'($urandom_range(0, 255));
        rb   = 8'($urandom_range(0, 255));
        rbin = 1'($urandom_range(0, 1));
        model(ra, rb, rbin, m_dif, m_bor, m_ovf, m_zero);
        run_op(k, ra, rb, rbin, m_dif, m_bor, m_ovf, m_zero, $sformatf("rnd%0d_%0d", k, n));
      end
    end

    // Mid-operation reset: make sure a nonzero result is on the ports first
    run_op(0, 8'h40, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0, "pre_rst");
    h_dif = dif[0];
    chk("pre_rst.nonzero", 32'(h_dif != 8'd0), 32'd1);
    @(negedge clk);
    a_s = 8'h05; b_s = 8'h03; bin_s = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.in_ready", 32'(in_ready[0]), 32'd0);
    chk("mrst.out_valid", 32'(out_valid[0]), 32'd0);
    chk("mrst.dif", 32'(dif[0]), 32'd0);
    chk("mrst.flags", 32'({bor[0], ovf[0], zero[0]}), 32'd0);
    vcnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid[0]) vcnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid[0]) vcnt++;
    end
    chk("mrst.no_out_valid", 32'(vcnt), 32'd0);
    run_op(0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
